// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: FSM state, owner index type and hold-limit default shared by reg_arb and rr_pick.
package reg_arb_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_e;
  typedef logic [1:0] owner_t;
  localparam int HOLD_MAX_DEF = 8;
endpackage

// File: rtl/reg_arb_rr_pick.sv
// rr_pick: combinational round-robin pick of the first request at or after ptr, wrapping 3 -> 0.
module rr_pick
  import reg_arb_pkg::*;
(
  input  logic [3:0] req_i,
  input  owner_t     ptr_i,
  output logic [3:0] onehot_o,
  output owner_t     index_o,
  output logic       any_o
);
  // Scanning from the farthest slot back toward ptr lets the nearest request win.
  always_comb begin
    index_o = '0;
    for (int i = 3; i >= 0; i--)
      index_o = req_i[ptr_i + owner_t'(i)] ? ptr_i + owner_t'(i) : index_o;
    any_o = |req_i;
    onehot_o = any_o ? 4'b0001 << index_o : 4'b0000;
  end
endmodule

// File: rtl/reg_arb.sv
// reg_arb: round-robin arbiter granting one of four requesters access to a shared register.
// Define REG_ARB_TIMEOUT_EN to force a release after HOLD_MAX consecutive locked cycles.
module reg_arb
  import reg_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 16,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ-1:0]       we_i,
  input  logic [N_REQ-1:0]       lock_i,
  input  logic [N_REQ*WIDTH-1:0] wdata_i,
  input  logic [WIDTH-1:0]       reg_out_i,
  output logic [WIDTH-1:0]       reg_in_o,
  output logic                   reg_load_o,
  output logic [N_REQ-1:0]       gnt_o,
  output owner_t                 owner_o,
  output logic                   busy_o,
  output logic [WIDTH-1:0]       rdata_o
);
  if (N_REQ != 4 || HOLD_MAX < 1) begin : g_bad_cfg
    $error("reg_arb: N_REQ must be 4 and HOLD_MAX at least 1");
  end
  state_e           state_q, state_d;
  owner_t           owner_q, owner_d, ptr_q, ptr_d, pick_idx;
  logic [N_REQ-1:0] gnt_q, gnt_d, pick_oh;
  logic             pick_any, hold;
  assign busy_o = state_q == GRANT;
  // On release the pointer moves past the owner in the same cycle, so arbitrate from there.
  rr_pick u_pick (
    .req_i   (req_i),
    .ptr_i   (busy_o ? owner_q + 2'd1 : ptr_q),
    .onehot_o(pick_oh),
    .index_o (pick_idx),
    .any_o   (pick_any)
  );
`ifdef REG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign hold  = busy_o & req_i[owner_q] & lock_i[owner_q] & (cnt_q != CW'(HOLD_MAX - 1));
  assign cnt_d = hold ? cnt_q + 1'b1 : '0;
  always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
`else
  assign hold = busy_o & req_i[owner_q] & lock_i[owner_q];
`endif
  always_comb begin
    state_d = (hold | pick_any) ? GRANT : IDLE;
    owner_d = hold ? owner_q : pick_idx;
    gnt_d   = hold ? gnt_q : pick_oh;
    ptr_d   = (busy_o & ~hold) ? owner_q + 2'd1 : ptr_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end
  assign gnt_o      = gnt_q;
  assign owner_o    = owner_q;
  assign reg_load_o = busy_o & req_i[owner_q] & we_i[owner_q];
  assign reg_in_o   = busy_o ? wdata_i[owner_q*WIDTH +: WIDTH] : '0;
  assign rdata_o    = reg_out_i;
endmodule

// File: tb/tb_reg_arb.sv
// tb_reg_arb: directed and randomized checks of reg_arb against a behavioural arbiter model.
module tb_reg_arb;
  localparam int W  = 16;
  localparam int HM = 8;
  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  req = '0, we = '0, lock = '0;
  logic [63:0] wdata = '0;
  logic [15:0] ext_q = '0;
  logic [15:0] reg_in, rdata;
  logic        reg_load, busy;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  int checks = 0, failures = 0;
  bit en = 1'b0;
  typedef struct {
    bit          busy;
    int          owner;
    int          ptr;
    int          hold;
    logic [15:0] rg;
  } mdl_t;
  mdl_t m = '{busy: 1'b0, owner: 0, ptr: 0, hold: 0, rg: 16'h0};

  always #5 clk = ~clk;

  reg_arb #(.N_REQ(4), .WIDTH(W), .HOLD_MAX(HM)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .lock_i(lock), .wdata_i(wdata),
    .reg_out_i(ext_q), .reg_in_o(reg_in), .reg_load_o(reg_load), .gnt_o(gnt),
    .owner_o(owner), .busy_o(busy), .rdata_o(rdata)
  );

  // The external shared register the arbiter drives.
  always @(posedge clk) if (reg_load) ext_q <= reg_in;

  function automatic mdl_t step(mdl_t c, logic r, logic [3:0] rq, logic [3:0] w, logic [3:0] lk,
                                logic [63:0] wd);
    mdl_t n = c;
    bit keep;
    if (c.busy && rq[c.owner] && w[c.owner]) n.rg = wd[c.owner*16 +: 16];
    if (r) begin
      n.busy = 0; n.owner = 0; n.ptr = 0; n.hold = 0;
      return n;
    end
    keep = c.busy && rq[c.owner] && lk[c.owner];
`ifdef REG_ARB_TIMEOUT_EN
    if (c.hold + 1 >= HM) keep = 0;
`endif
    if (keep) n.hold = c.hold + 1;
    else begin
      if (c.busy) n.ptr = (c.owner + 1) % 4;
      n.busy = 0; n.hold = 0;
      for (int j = 0; j < 4; j++)
        if (!n.busy && rq[(n.ptr + j) % 4]) begin
          n.busy = 1; n.owner = (n.ptr + j) % 4;
        end
    end
    return n;
  endfunction

  always @(posedge clk) m <= step(m, rst, req, we, lock, wdata);

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (en) begin
    chk("gnt", 64'(gnt), m.busy ? 64'd1 << m.owner : 64'd0);
    chk("busy", 64'(busy), 64'(m.busy));
    if (m.busy) chk("owner", 64'(owner), 64'(m.owner));
    chk("load", 64'(reg_load), 64'(m.busy && req[m.owner] && we[m.owner]));
    chk("reg_in", 64'(reg_in), m.busy ? 64'(wdata[m.owner*16 +: 16]) : 64'd0);
    chk("rdata", 64'(rdata), 64'(m.rg));
    chk("onehot", 64'($countones(gnt) <= 1), 64'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    req = 4'b1111; we = 4'b1111;
    tick; en = 1'b1;
    tick; #2;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_load", 64'(reg_load), 64'd0);
    rst = 1'b0; we = '0; lock = '0;
    for (int i = 0; i < 5; i++) begin
      tick; #2;
      chk("rr_seq", 64'(gnt), 64'd1 << (i % 4));
    end
    req = '0; tick; tick;
    req = 4'b0100; we = 4'b0100;
    wdata = {$urandom, $urandom}; wdata[47:32] = 16'hBEEF;
    tick; #2;
    chk("wr_gnt", 64'(gnt), 64'h4);
    chk("wr_load", 64'(reg_load), 64'd1);
    chk("wr_data", 64'(reg_in), 64'hBEEF);
    tick; #2;
    chk("wr_rdata", 64'(rdata), 64'hBEEF);
    req = '0; we = '0; tick; tick;
    req = 4'b0011; lock = 4'b0001;
    for (int i = 0; i < 9; i++) begin
      tick; #2;
`ifdef REG_ARB_TIMEOUT_EN
      chk("lock_gnt", 64'(gnt), i < HM ? 64'h1 : 64'h2);
`else
      chk("lock_gnt", 64'(gnt), 64'h1);
`endif
    end
    req = '0; lock = '0; tick; tick;
    req = 4'b0010; we = 4'b0010; lock = 4'b0010;
    tick; #2;
    chk("mid_gnt", 64'(gnt), 64'h2);
    chk("mid_load", 64'(reg_load), 64'd1);
    rst = 1'b1;
    tick; #2;
    chk("mid_rst_gnt", 64'(gnt), 64'd0);
    chk("mid_rst_load", 64'(reg_load), 64'd0);
    rst = 1'b0; req = 4'b1111; lock = '0; we = '0;
    tick; #2;
    chk("post_rst_gnt", 64'(gnt), 64'h1);
    for (int i = 0; i < 3000; i++) begin
      tick;
      rst   = ($urandom_range(0, 63) == 0);
      req   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : req;
      we    = 4'($urandom);
      lock  = 4'($urandom | $urandom);
      wdata = {$urandom, $urandom};
    end
    tick; tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
